// File: rtl/rr_lock_sequencer.sv
// Round-robin burst sequencer: grants one requester at a time a lock/busy/done
// window on a shared resource, rotating priority after every completed window.

module rr_lock_len_lane #(
  parameter int LEN_W = 4
) (
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] start_cnt
);
  // A zero length is run as a single beat.
  assign start_cnt = (len == '0) ? '0 : len - 1'b1;
endmodule

module rr_lock_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] len,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     lock,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [LEN_W-1:0]         beat_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                          state, state_n;
  logic [ID_W-1:0]                 ptr, ptr_n;
  logic [NUM_REQ-1:0][LEN_W-1:0]   start_cnt;
  logic [ID_W-1:0]                 win;
  logic                            found;
  logic [NUM_REQ-1:0]              gnt_n;
  logic [ID_W-1:0]                 gnt_id_n;
  logic                            lock_n, busy_n, done_n, aborted_n;
  logic [LEN_W-1:0]                beat_n;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    rr_lock_len_lane #(.LEN_W(LEN_W)) u_lane (
      .len       (len[i*LEN_W +: LEN_W]),
      .start_cnt (start_cnt[i])
    );
  end

  // Rotating scan starting at ptr; first set request wins.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      lock     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      lock     <= lock_n;
      busy     <= busy_n;
      done     <= done_n;
      aborted  <= aborted_n;
      beat_cnt <= beat_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (found) state_n = BUSY;
      BUSY:    if (beat_cnt == '0 || abort) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    lock_n    = lock;
    busy_n    = busy;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    beat_n    = beat_cnt;
    ptr_n     = ptr;
    case (state)
      IDLE: if (found) begin
        gnt_n      = '0;
        gnt_n[win] = 1'b1;
        gnt_id_n   = win;
        lock_n     = 1'b1;
        busy_n     = 1'b1;
        beat_n     = start_cnt[win];
      end
      BUSY: if (beat_cnt == '0 || abort) begin
        busy_n    = 1'b0;
        done_n    = 1'b1;
        aborted_n = abort;
        beat_n    = '0;
      end else begin
        beat_n = beat_cnt - 1'b1;
      end
      DONE: begin
        // Lock stays up through the done cycle and drops here.
        gnt_n    = '0;
        gnt_id_n = '0;
        lock_n   = 1'b0;
        busy_n   = 1'b0;
        beat_n   = '0;
        ptr_n    = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
      default: begin
        gnt_n    = '0;
        gnt_id_n = '0;
        lock_n   = 1'b0;
        busy_n   = 1'b0;
        beat_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_lock_sequencer.sv
// Bench for rr_lock_sequencer: cycle vector table through a scoreboard queue,
// a grant-order sequence, and per-cycle protocol invariants.

module tb_rr_lock_sequencer;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] len;
  logic                     abort;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_id;
  logic                     lock, busy, done, aborted;
  logic [LEN_W-1:0]         beat_cnt;

  rr_lock_sequencer #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len      (len),
    .abort    (abort),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .lock     (lock),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] req;
    logic [15:0] len;
    logic       abort;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       lock, busy, done, ab;
    logic [3:0] beat;
  } vec_t;

  vec_t tv[$];
  vec_t sb[$];
  vec_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int r, input logic [3:0] q, input logic [15:0] l, input int a,
                     input logic [3:0] g, input int i, input int lk, input int bz,
                     input int dn, input int ab, input int bt);
    vec_t v;
    v.n = tv.size(); v.rst = 1'(r); v.req = q; v.len = l; v.abort = 1'(a);
    v.gnt = g; v.id = 2'(i); v.lock = 1'(lk); v.busy = 1'(bz);
    v.done = 1'(dn); v.ab = 1'(ab); v.beat = 4'(bt);
    tv.push_back(v);
  endtask

  // Scoreboard: each vector's expectation is popped once the DUT has taken the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({gnt, gnt_id, lock, busy, done, aborted, beat_cnt} ==
          {e.gnt, e.id, e.lock, e.busy, e.done, e.ab, e.beat})
        n_pass++;
      else
        $display("FAIL row%0d: got gnt=%b id=%0d lock=%b busy=%b done=%b ab=%b beat=%0d, want gnt=%b id=%0d lock=%b busy=%b done=%b ab=%b beat=%0d",
                 e.n, gnt, gnt_id, lock, busy, done, aborted, beat_cnt,
                 e.gnt, e.id, e.lock, e.busy, e.done, e.ab, e.beat);
    end
  end

  logic p_lock = 1'b0, p_busy = 1'b0, p_done = 1'b0;
  int   wdone  = 0;

  always @(posedge clk) begin
    logic ok;
    int   wd;
    #1;
    ok = 1'b1;
    wd = wdone;
    if (busy && !lock) ok = 1'b0;
    if ((busy && !p_busy) != (lock && !p_lock)) ok = 1'b0;
    if (done && !(!busy && lock)) ok = 1'b0;
    if (lock ? !$onehot(gnt) : (gnt != '0)) ok = 1'b0;
    if (lock && gnt != (4'b0001 << gnt_id)) ok = 1'b0;
    if (done && p_done) ok = 1'b0;
    if (aborted && !done) ok = 1'b0;
    if (lock && !p_lock) wd = 0;
    if (done) wd = wd + 1;
    if (!lock && p_lock && !rst && wd != 1) ok = 1'b0;
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL invariant @%0t: got lock=%b busy=%b done=%b ab=%b gnt=%b id=%0d dones=%0d, want protocol-consistent outputs",
                  $time, lock, busy, done, aborted, gnt, gnt_id, wd);
    wdone  <= wd;
    p_lock <= lock;
    p_busy <= busy;
    p_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1);
  end

  int gq[$];
  int prev_cyc, exp_id;
  logic pl;

  initial begin
    rst = 1'b1; req = '0; len = '0; abort = 1'b0;

    //  rst req      len       ab  gnt     id lk bz dn ab beat
    add(1, 4'b0000, 16'h0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 16'h0030, 0, 4'b0010, 1, 1, 1, 0, 0, 2);
    add(0, 4'b0000, 16'h0030, 0, 4'b0010, 1, 1, 1, 0, 0, 1);
    add(0, 4'b0000, 16'h0030, 0, 4'b0010, 1, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 16'h0030, 0, 4'b0010, 1, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 16'h0030, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 16'h0000, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 16'h0000, 0, 4'b0001, 0, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1100, 16'h1800, 0, 4'b0100, 2, 1, 1, 0, 0, 7);
    add(0, 4'b1000, 16'h1800, 0, 4'b0100, 2, 1, 1, 0, 0, 6);
    add(0, 4'b1000, 16'h1800, 0, 4'b0100, 2, 1, 1, 0, 0, 5);
    add(0, 4'b1000, 16'h1800, 1, 4'b0100, 2, 1, 0, 1, 1, 0);
    add(0, 4'b1000, 16'h1800, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1000, 16'h1800, 0, 4'b1000, 3, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 16'h1800, 0, 4'b1000, 3, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 16'h1800, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 16'h0060, 1, 4'b0010, 1, 1, 1, 0, 0, 5);
    add(0, 4'b0010, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 4);
    add(0, 4'b0010, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 3);
    add(0, 4'b0010, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 2);
    add(1, 4'b0010, 16'h0060, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0110, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 5);
    add(0, 4'b0000, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 4);
    add(0, 4'b0000, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 3);
    add(0, 4'b0000, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 2);
    add(0, 4'b0000, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 1);
    add(0, 4'b0000, 16'h0060, 0, 4'b0010, 1, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 16'h0060, 0, 4'b0010, 1, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 16'h0060, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 16'h0002, 0, 4'b0001, 0, 1, 1, 0, 0, 1);
    add(0, 4'b1000, 16'h0002, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 16'h0002, 0, 4'b0001, 0, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 16'h0002, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 16'h0002, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 16'h0002, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0100, 16'h0500, 0, 4'b0100, 2, 1, 1, 0, 0, 4);
    add(0, 4'b0000, 16'h0500, 1, 4'b0100, 2, 1, 0, 1, 1, 0);
    add(0, 4'b0000, 16'h0500, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 16'h0001, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 16'h0001, 1, 4'b0001, 0, 1, 0, 1, 1, 0);
    add(0, 4'b0000, 16'h0001, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; req = tv[i].req; len = tv[i].len; abort = tv[i].abort;
      sb.push_back(tv[i]);
    end
    @(negedge clk);

    // All four requesting with unit lengths: grants rotate 0,1,2,3,0 every 3 cycles.
    rst = 1'b1; req = '0; abort = 1'b0; len = 16'h1111;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    pl = 1'b0;
    prev_cyc = -1;
    for (int cyc = 0; cyc < 40 && gq.size() != 0; cyc++) begin
      @(posedge clk);
      #1;
      if (lock && !pl) begin
        exp_id = gq.pop_front();
        n_checks++;
        if (gnt_id == 2'(exp_id) && gnt == (4'b0001 << exp_id)) n_pass++;
        else $display("FAIL rr_order: got id=%0d gnt=%b, want id=%0d", gnt_id, gnt, exp_id);
        if (prev_cyc >= 0) begin
          n_checks++;
          if (cyc - prev_cyc == 3) n_pass++;
          else $display("FAIL rr_spacing: got %0d cycles, want 3", cyc - prev_cyc);
        end
        prev_cyc = cyc;
      end
      pl = lock;
    end
    n_checks++;
    if (gq.size() == 0) n_pass++;
    else $display("FAIL rr_timeout: got %0d grants outstanding, want 0", gq.size());

    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_lock_sequencer.md
Name: rr_lock_sequencer

Overview:
- Round-robin controller that shares one burst resource among NUM_REQ requesters.
- For each winner it runs a burst window: `lock` (hold) and `busy` (active) rise together, `busy` runs for the requested length, then `done` pulses while `lock` is still high.
- Sits between the requester ports and the shared datapath.
- Its output protocol is the one checked by the team's throughout-style assertions: lock held throughout busy, done coincident with busy falling.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- LEN_W, 4, width of each burst-length field.
- ID_W, $clog2(NUM_REQ), width of `gnt_id`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per requester; level, held until granted.
- len  in  NUM_REQ*LEN_W  packed burst length per requester; field i is len[i*LEN_W +: LEN_W].
- abort  in  1  terminates the current burst early.
- gnt  out  NUM_REQ  one-hot grant; held for the whole window.
- gnt_id  out  ID_W  index of the granted requester.
- lock  out  1  resource hold; high from the burst start through the done cycle.
- busy  out  1  resource active.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle pulse, coincident with `done`, when the window ended by abort.
- beat_cnt  out  LEN_W  remaining beats minus 1 while busy; 0 otherwise.

Behaviour:
- All outputs are registered.
- Reset (sampled at a clk edge with rst=1):
  - state=IDLE; gnt=0, gnt_id=0, lock=0, busy=0, done=0, aborted=0, beat_cnt=0.
  - Round-robin pointer ptr=0.
  - Reset mid-burst drops all outputs at that edge. No done is generated.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Next edge: state=BUSY; gnt=onehot(winner); gnt_id=winner; lock=1; busy=1.
  - beat_cnt = max(len[winner],1) - 1, so len=0 is treated as 1.
  - Latency from req sampled to lock/busy high: 1 cycle.
  - `len` is sampled only at this edge.
- BUSY:
  - beat_cnt decrements each cycle.
  - When beat_cnt==0 or abort==1: next edge state=DONE; busy=0; done=1; aborted=abort; lock and gnt unchanged.
  - busy is therefore high for exactly max(len,1) cycles without abort.
  - Abort in the first BUSY cycle gives busy high for 1 cycle.
  - If abort and beat_cnt==0 are both true, aborted=1.
- DONE (1 cycle):
  - Next edge: state=IDLE; lock=0; gnt=0; done=0; aborted=0; ptr=(winner+1) mod NUM_REQ.
  - Requests are not evaluated in DONE.
  - Minimum spacing between windows is 1 IDLE cycle, so lock has a fresh rising edge per burst.
  - Throughput: max(len,1)+2 cycles per grant.
- `req` changes while not in IDLE are ignored.
  - A requester whose req drops mid-burst still completes its burst.
  - A requester holding req after done competes again at lowest priority.
- `abort` is ignored outside BUSY.
- Invariants (bench asserts these):
  - busy implies lock.
  - $rose(busy) equals $rose(lock).
  - done implies (!busy && lock).
  - Each window has exactly one done.
  - gnt is one-hot when lock is high, and 0 otherwise.
  - gnt_id is consistent with gnt.
  - done is never asserted in consecutive cycles.

Test Plan:
1. Single request, req=4'b0010, len[1]=3 → 1 cycle later lock=busy=1, gnt=0010, gnt_id=1, beat_cnt 2,1,0. busy falls after 3 cycles with done=1, lock=1. lock=0 the next cycle; ptr=2.
2. All four requesting continuously, all len=1 → grants in order 0,1,2,3,0 every 3 cycles. Each window shows busy 1 cycle, done 1 cycle, then an idle gap with lock=0.
3. len[0]=0 with req=4'b0001 → busy high for exactly 1 cycle, then done. beat_cnt stays 0.
4. len[2]=8; assert abort on the 3rd BUSY cycle → busy drops after 3 cycles with done=1, aborted=1, lock still 1. A grant to requester 3 follows if it is requesting.
5. len[1]=6; assert rst during the 4th BUSY cycle → at that edge all outputs are 0, no done. After release, req=4'b0110 grants requester 1 (ptr=0).
6. req[3] pulses for one cycle while requester 0 is BUSY → no grant to 3 is ever issued. Invariant assertions hold across scenarios 1-5.
